// File: rtl/game_frame_sequencer_if.sv
// Signal bundle between the game-flow sequencer and its neighbours: player controls and hit
// pulses in, colorizer frame selects, lives and round_reset out.
interface game_frame_sequencer_if;
    logic       start_btn;
    logic       map_sel;
    logic       tank_hit;
    logic       train_hit;
    logic       frame1;
    logic       frame2;
    logic       frame3;
    logic       frame4;
    logic       frame5;
    logic [2:0] tank_lives;
    logic [2:0] train_lives;
    logic       round_reset;

    modport master (
        output start_btn, map_sel, tank_hit, train_hit,
        input  frame1, frame2, frame3, frame4, frame5, tank_lives, train_lives, round_reset
    );

    modport slave (
        input  start_btn, map_sel, tank_hit, train_hit,
        output frame1, frame2, frame3, frame4, frame5, tank_lives, train_lives, round_reset
    );
endinterface

// File: rtl/game_frame_sequencer.sv
// Game-flow state machine: title, two maps and two win screens, with per-player lives,
// a post-hit guard window and a timed return from the win screens to the title.
module game_frame_sequencer #(
    parameter int unsigned LIVES     = 3,
    parameter int unsigned HIT_GUARD = 25_000_000,
    parameter int unsigned WIN_HOLD  = 150_000_000
) (
    input logic                   clk,
    input logic                   rst_n,
    game_frame_sequencer_if.slave bus
);

    localparam int unsigned GuardW = (HIT_GUARD > 1) ? $clog2(HIT_GUARD) : 1;
    localparam int unsigned HoldW  = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

    localparam logic [2:0]        LivesInit = 3'(LIVES);
    localparam logic [GuardW-1:0] GuardLoad = GuardW'(HIT_GUARD - 1);
    localparam logic [GuardW-1:0] GuardOne  = GuardW'(1);
    localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(WIN_HOLD - 1);
    localparam logic [HoldW-1:0]  HoldOne   = HoldW'(1);

    typedef enum logic [2:0] {
        StTitle,
        StPlay1,
        StPlay2,
        StTwin,
        StRwin
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        tank_lives_q, tank_lives_d;
    logic [2:0]        train_lives_q, train_lives_d;
    logic [GuardW-1:0] tank_guard_q, tank_guard_d;
    logic [GuardW-1:0] train_guard_q, train_guard_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              start_q;
    logic              round_reset_q, round_reset_d;

    logic start_rise;
    logic tank_take, train_take;
    logic tank_out, train_out;

    assign start_rise = bus.start_btn & ~start_q;

    always_comb begin
        state_d       = state_q;
        tank_lives_d  = tank_lives_q;
        train_lives_d = train_lives_q;
        tank_guard_d  = tank_guard_q;
        train_guard_d = train_guard_q;
        hold_d        = hold_q;
        round_reset_d = 1'b0;
        tank_take     = 1'b0;
        train_take    = 1'b0;
        tank_out      = 1'b0;
        train_out     = 1'b0;

        case (state_q)
            StTitle: begin
                if (start_rise) begin
                    state_d       = bus.map_sel ? StPlay2 : StPlay1;
                    tank_lives_d  = LivesInit;
                    train_lives_d = LivesInit;
                    tank_guard_d  = '0;
                    train_guard_d = '0;
                    round_reset_d = 1'b1;
                end
            end

            StPlay1, StPlay2: begin
                tank_take  = bus.tank_hit && (tank_guard_q == '0) && (tank_lives_q != 3'd0);
                train_take = bus.train_hit && (train_guard_q == '0) && (train_lives_q != 3'd0);

                if (tank_take) begin
                    tank_lives_d = tank_lives_q - 3'd1;
                    tank_guard_d = GuardLoad;
                end else if (tank_guard_q != '0) begin
                    tank_guard_d = tank_guard_q - GuardOne;
                end

                if (train_take) begin
                    train_lives_d = train_lives_q - 3'd1;
                    train_guard_d = GuardLoad;
                end else if (train_guard_q != '0) begin
                    train_guard_d = train_guard_q - GuardOne;
                end

                tank_out  = tank_take && (tank_lives_q == 3'd1);
                train_out = train_take && (train_lives_q == 3'd1);

                // Simultaneous knockout is a draw: straight back to the title, lives left at 0.
                if (tank_out && train_out) begin
                    state_d = StTitle;
                end else if (tank_out) begin
                    state_d = StRwin;
                    hold_d  = HoldLoad;
                end else if (train_out) begin
                    state_d = StTwin;
                    hold_d  = HoldLoad;
                end
            end

            StTwin, StRwin: begin
                if (hold_q == '0) begin
                    state_d = StTitle;
                end else begin
                    hold_d = hold_q - HoldOne;
                end
            end

            default: state_d = StTitle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StTitle;
            tank_lives_q  <= LivesInit;
            train_lives_q <= LivesInit;
            tank_guard_q  <= '0;
            train_guard_q <= '0;
            hold_q        <= '0;
            // Held high so a button already down through reset cannot start a game.
            start_q       <= 1'b1;
            round_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tank_lives_q  <= tank_lives_d;
            train_lives_q <= train_lives_d;
            tank_guard_q  <= tank_guard_d;
            train_guard_q <= train_guard_d;
            hold_q        <= hold_d;
            start_q       <= bus.start_btn;
            round_reset_q <= round_reset_d;
        end
    end

    assign bus.frame1      = (state_q == StTitle);
    assign bus.frame2      = (state_q == StPlay1);
    assign bus.frame3      = (state_q == StPlay2);
    assign bus.frame4      = (state_q == StTwin);
    assign bus.frame5      = (state_q == StRwin);
    assign bus.tank_lives  = tank_lives_q;
    assign bus.train_lives = train_lives_q;
    assign bus.round_reset = round_reset_q;

endmodule
